// File: rtl/usb_nint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_nint_pkg
// Description : Shared constants for the USB nINT conditioner: register map,
//               status bit positions, default filter threshold and the
//               threshold helper used by the stability filter.
// Revision    : 1.0  initial release
// ============================================================================
package usb_nint_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_THRESH = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  // Bit positions inside the status word
  localparam int STS_LEVEL = 0;
  localparam int STS_SYNC  = 1;
  localparam int STS_PEND  = 2;

  // Default number of stable cycles needed to change int_level
  localparam int FILTER_RESET_DEF = 4;

  localparam int THR_W = 8;
  typedef logic [THR_W-1:0] thr_t;

  // A programmed threshold of zero behaves exactly like one
  function automatic thr_t eff_thr(input thr_t thr);
    return (thr == '0) ? thr_t'(1) : thr;
  endfunction

endpackage : usb_nint_pkg
`default_nettype wire

// File: rtl/usb_nint_filter.sv
`default_nettype none
// ============================================================================
// Module      : usb_nint_filter
// Description : Synchronises the raw active-low nINT pin, then qualifies it
//               with a stability counter feeding a two-state level FSM.
//               Produces the clean active-high level and a one-cycle rise
//               strobe aligned with the cycle the level goes high.
// Revision    : 1.0  initial release
// ============================================================================
module usb_nint_filter
  import usb_nint_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  thr_t thr_i,
  input  logic thr_wr_i,
  output logic sync_o,
  output logic level_o,
  output logic rise_o
);

  localparam logic [0:0] ST_DEASSERTED = 1'b0;
  localparam logic [0:0] ST_ASSERTED   = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [0:0]             state_q, state_d;
  thr_t                   cnt_q, cnt_d;
  thr_t                   thr_eff;
  logic                   sync;
  logic                   level_now;

  // Pin synchroniser; stage 0 feeds only stage 1, inactive (high) out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign sync      = ~sync_q[SYNC_STAGES-1];
  assign thr_eff   = eff_thr(thr_i);
  assign level_now = (state_q == ST_ASSERTED);

  // Count consecutive disagreeing cycles; toggle the level when the run
  // reaches the threshold. A threshold write restarts the run without
  // touching the current level.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (thr_wr_i) begin
      cnt_d = '0;
    end else if (sync != level_now) begin
      if (cnt_q == thr_eff - thr_t'(1)) begin
        state_d = level_now ? ST_DEASSERTED : ST_ASSERTED;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + thr_t'(1);
      end
    end
  end

  // FSM state and stability counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_DEASSERTED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o  = sync;
  assign level_o = level_now;
  assign rise_o  = (state_d == ST_ASSERTED) && (state_q == ST_DEASSERTED);

endmodule : usb_nint_filter
`default_nettype wire

// File: rtl/usb_nint_cond.sv
`default_nettype none
// ============================================================================
// Module      : usb_nint_cond
// Description : nINT pin conditioner for the usb_nint PIO. Wraps the
//               glitch filter with a sticky pending flag, a saturating
//               event counter and a four-word Avalon-MM register file.
// Revision    : 1.0  initial release
// ============================================================================
module usb_nint_cond
  import usb_nint_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_RESET = FILTER_RESET_DEF,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        usb_nint_pin,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        int_level,
  output logic        int_pending
);

  logic             wr_en;
  logic             thr_wr;
  logic             cnt_clr;
  logic             pend_clr;
  logic             rise;
  logic             sync;
  logic             level;
  thr_t             thr_q, thr_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wdata;

  assign wr_en    = chipselect && !write_n;
  assign thr_wr   = wr_en && (address == ADDR_THRESH);
  assign cnt_clr  = wr_en && (address == ADDR_COUNT);
  assign pend_clr = wr_en && (address == ADDR_CLEAR) && writedata[0];

  // Only the low threshold byte and the W1C bit carry meaning
  assign unused_wdata = ^writedata[31:8];

  usb_nint_filter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_filter (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .pin_i    (usb_nint_pin),
    .thr_i    (thr_q),
    .thr_wr_i (thr_wr),
    .sync_o   (sync),
    .level_o  (level),
    .rise_o   (rise)
  );

  // Next-state for threshold, pending flag and event counter; a rise beats
  // a same-cycle clear of either the flag or the counter
  always_comb begin
    thr_d     = thr_wr ? writedata[THR_W-1:0] : thr_q;
    pending_d = pending_q;
    if (rise) begin
      pending_d = 1'b1;
    end else if (pend_clr) begin
      pending_d = 1'b0;
    end
    count_d = count_q;
    if (cnt_clr) begin
      count_d = rise ? CNT_W'(1) : '0;
    end else if (rise && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Read mux; address is decoded regardless of chipselect
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS: begin
        readdata_d[STS_LEVEL] = level;
        readdata_d[STS_SYNC]  = sync;
        readdata_d[STS_PEND]  = pending_q;
      end
      ADDR_COUNT:  readdata_d = 32'(count_q);
      ADDR_THRESH: readdata_d = 32'(thr_q);
      ADDR_CLEAR:  readdata_d[0] = pending_q;
      default:     readdata_d = '0;
    endcase
  end

  // Register file state and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_q      <= thr_t'(FILTER_RESET);
      pending_q  <= 1'b0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      thr_q      <= thr_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata    = readdata_q;
  assign int_level   = level;
  assign int_pending = pending_q;

endmodule : usb_nint_cond
`default_nettype wire

// File: doc/usb_nint_cond.md
Name: usb_nint_cond

Overview:
- Conditions the raw, asynchronous, active-low nINT pin from the external USB host/device controller before it reaches the usb_nint PIO input (in_port).
- Synchronises the pin, rejects glitches with a programmable stability filter, and captures assertion edges into a sticky pending bit.
- Counts interrupt events for driver diagnostics, exposed through a small Avalon-MM slave on the same bus as usb_nint.
- Outputs a clean active-high level (int_level) to usb_nint.in_port and a pending flag (int_pending).

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the pin synchroniser chain; legal range 2..4.
- FILTER_RESET, 4, reset value of the filter threshold register (cycles of stability required); legal range 1..255.
- CNT_W, 16, width of the saturating event counter; legal range 1..32.

Ports:
- clk  input  1  system clock; all logic is in this single domain.
- reset_n  input  1  asynchronous active-low reset.
- usb_nint_pin  input  1  raw nINT from the USB chip; asynchronous, active-low.
- address  input  2  Avalon word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  Avalon write strobe, active-low.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data, registered.
- int_level  output  1  filtered interrupt level, active-high; drives usb_nint.in_port.
- int_pending  output  1  sticky "assertion seen" flag.

Behaviour:
- Reset (async, reset_n=0):
  - Synchroniser flops are set to 1 (pin inactive).
  - int_level=0, int_pending=0, event count=0, threshold=FILTER_RESET, stability counter=0, readdata=0.
- Synchroniser:
  - sync = inverted output of the last stage of the SYNC_STAGES chain, so sync is active-high.
  - No logic other than the next synchroniser stage may read stage 1.
- Filter FSM, two states:
  - DEASSERTED (int_level=0) and ASSERTED (int_level=1).
  - The 8-bit stability counter increments each cycle that sync differs from int_level.
  - The counter clears to 0 on any cycle where sync equals int_level.
  - When sync differs and the counter equals thr-1, the state toggles and the counter clears in that same cycle.
  - thr is the threshold register value; a threshold of 0 is treated as 1.
  - Latency from pin edge to int_level change is SYNC_STAGES + thr cycles, ±1 for pin-edge phase.
  - A pulse shorter than thr sync cycles produces no change on int_level.
- Edge capture: rise = int_level_next & ~int_level.
  - rise sets int_pending and increments the event counter.
  - The counter saturates at all-ones and never wraps.
- Register map. Reads return in the cycle after address is presented and are not gated by chipselect. Unused bits read 0.
  - addr0 (R): bit0=int_level, bit1=sync, bit2=int_pending.
  - addr1 (R/W): event counter in bits [CNT_W-1:0]; any write clears it to 0.
  - addr2 (R/W): filter threshold in bits [7:0]. A write takes effect on the next cycle and also clears the stability counter.
  - addr3 (W1C): writing 1 to bit0 clears int_pending. Reads return {31'b0, int_pending}.
- Writes occur when chipselect && !write_n.
- Simultaneous events:
  - rise and W1C in the same cycle: int_pending stays 1 (set wins).
  - rise and counter clear in the same cycle: counter becomes 1.
  - rise while the counter is saturated: counter holds.
- Threshold rewrite mid-qualification restarts qualification from 0; the FSM state is unchanged.
- Reset asserted mid-qualification: everything returns to reset values immediately and asynchronously.
- Deassertion (ASSERTED→DEASSERTED) uses the same threshold. It does not affect int_pending or the counter.

Decomposition:
- Shared package usb_nint_pkg holds:
  - address constants ADDR_STATUS=0, ADDR_COUNT=1, ADDR_THRESH=2, ADDR_CLEAR=3;
  - status bit indices;
  - default FILTER_RESET.
- One sub-module, usb_nint_filter: synchroniser chain, stability counter and the two-state FSM, outputting int_level and rise.
- The top level contains the Avalon register file, pending flag and event counter.

Test Plan:
- Reset then idle pin=1 for 20 cycles -> int_level=0, int_pending=0, addr1 reads 0, addr2 reads 4.
- Pin driven 0 and held -> int_level rises exactly 2+4 cycles after the edge (±1). addr0 reads 0x7 and addr1 reads 1. Pin released: int_level falls after the same delay and addr0 reads 0x4.
- Pin 0-glitches of 3 cycles with threshold=4, repeated 10 times -> int_level never rises and addr1 stays 0. With threshold written to 2, the same glitch yields one event per glitch.
- Write addr3=0x1 on the exact cycle a rise occurs -> int_pending remains 1. A W1C one cycle later clears it, and addr0 bit2 reads 0.
- With CNT_W=4, generate 17 qualified assertions -> addr1 reads 0xF. A write to addr1 gives 0, and the next assertion gives 1.
- Assert reset_n=0 while int_level=1 and mid-count -> outputs 0 immediately and threshold returns to 4. After release with the pin still 0, int_level rises 6 cycles later.
